// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE/REQ/RESP, 2 bits)
//   arb_owner_e : owner of the in-flight transaction (INST=0, DATA=1)
//   arb_req_t   : latched request bundle (wen + addr + wdata)
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_INST = 1'b0,
        ARB_OWN_DATA = 1'b1
    } arb_owner_e;

    localparam int unsigned ARB_REQ_BUS_W = 4 + 32 + 32;

    typedef struct packed {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/arb_pick.sv
// Winner selection for the memory port arbiter (purely combinational).
// Ports:
//   inst_req, data_req : pending requests from the fetch and data sides
//   streak             : consecutive data grants made while fetch was waiting
//   grant_data         : 1 = data side wins, 0 = fetch side wins
//   streak_next        : streak value to store if this grant is taken
module arb_pick #(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned STREAK_W        = 3
) (
    input  logic                inst_req,
    input  logic                data_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_data,
    output logic [STREAK_W-1:0] streak_next
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_SAT = '1;
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    always_comb begin
        grant_data  = 1'b0;
        streak_next = '0;
        // Data wins conflicts until it has starved fetch for MAX_DATA_STREAK grants.
        if (data_req && inst_req) begin
            grant_data = (streak < STREAK_MAX);
        end else begin
            grant_data = data_req;
        end
        // Only count data grants that actually made fetch wait.
        if (grant_data && inst_req) begin
            streak_next = (streak == STREAK_SAT) ? streak : streak + STREAK_ONE;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and
// data access, one outstanding transaction at a time.
// Ports:
//   clk, rst                     : clock, synchronous active-low reset
//   inst_* / data_* (inputs)     : request, byte enables, address, write data
//   inst_* / data_* (outputs)    : addr_ok / data_ok pulses and read data
//   mem_req/wen/addr/wdata       : request toward memory, driven from latches
//   mem_addr_ok/data_ok/rdata    : memory handshake and read data
//   stallreq_for_mem             : pipeline stall request while anyone waits
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned STREAK_W        = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [3:0]  inst_wen,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        stallreq_for_mem
);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    arb_req_t            req_q, req_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic                grant_data;
    logic [STREAK_W-1:0] pick_streak;

    arb_pick #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK),
        .STREAK_W       (STREAK_W)
    ) u_pick (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .streak     (streak_q),
        .grant_data (grant_data),
        .streak_next(pick_streak)
    );

    // Read data is a plain passthrough; it is only meaningful with data_ok.
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    assign mem_wen   = req_q.wen;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        req_d            = req_q;
        streak_d         = streak_q;
        mem_req          = 1'b0;
        inst_addr_ok     = 1'b0;
        data_addr_ok     = 1'b0;
        inst_data_ok     = 1'b0;
        data_data_ok     = 1'b0;
        stallreq_for_mem = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                stallreq_for_mem = inst_req | data_req;
                if (inst_req || data_req) begin
                    streak_d = pick_streak;
                    state_d  = ARB_REQ;
                    if (grant_data) begin
                        owner_d     = ARB_OWN_DATA;
                        req_d.wen   = data_wen;
                        req_d.addr  = data_addr;
                        req_d.wdata = data_wdata;
                    end else begin
                        owner_d     = ARB_OWN_INST;
                        req_d.wen   = inst_wen;
                        req_d.addr  = inst_addr;
                        req_d.wdata = inst_wdata;
                    end
                end
            end
            ARB_REQ: begin
                mem_req          = 1'b1;
                stallreq_for_mem = 1'b1;
                if (mem_addr_ok) begin
                    inst_addr_ok = (owner_q == ARB_OWN_INST);
                    data_addr_ok = (owner_q == ARB_OWN_DATA);
                    state_d      = ARB_RESP;
                end
            end
            ARB_RESP: begin
                stallreq_for_mem = 1'b1;
                if (mem_data_ok) begin
                    inst_data_ok = (owner_q == ARB_OWN_INST);
                    data_data_ok = (owner_q == ARB_OWN_DATA);
                    state_d      = ARB_IDLE;
                    // The pipeline may proceed only if the other side is not waiting.
                    if (owner_q == ARB_OWN_INST) begin
                        stallreq_for_mem = data_req;
                    end else begin
                        stallreq_for_mem = inst_req;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // Outputs are silenced while reset is held, so an in-flight response is dropped.
        if (!rst) begin
            mem_req          = 1'b0;
            inst_addr_ok     = 1'b0;
            data_addr_ok     = 1'b0;
            inst_data_ok     = 1'b0;
            data_data_ok     = 1'b0;
            stallreq_for_mem = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= ARB_OWN_INST;
            req_q    <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            req_q    <= req_d;
            streak_q <= streak_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. A second instance with
// MAX_DATA_STREAK=0 shares all inputs and is only checked in its own test.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req, mem_addr_ok, mem_data_ok;
    logic [3:0]  inst_wen, data_wen;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, mem_rdata;

    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_req, stall;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wen;

    logic        z_inst_addr_ok, z_inst_data_ok, z_data_addr_ok, z_data_data_ok, z_mem_req;
    logic        z_stall;
    logic [31:0] z_inst_rdata, z_data_rdata, z_mem_addr, z_mem_wdata;
    logic [3:0]  z_mem_wen;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_DATA_STREAK(4), .STREAK_W(3)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wen(inst_wen), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .stallreq_for_mem(stall)
    );

    mem_port_arbiter #(.MAX_DATA_STREAK(0), .STREAK_W(3)) dut0 (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wen(inst_wen), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_addr_ok(z_inst_addr_ok),
        .inst_data_ok(z_inst_data_ok), .inst_rdata(z_inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(z_data_addr_ok),
        .data_data_ok(z_data_data_ok), .data_rdata(z_data_rdata),
        .mem_req(z_mem_req), .mem_wen(z_mem_wen), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .stallreq_for_mem(z_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let combinational outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wen = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_d [10];
        logic [2:0] exp_streak [10];

        // ---------------- reset: outputs quiet even with requests and stale response
        clear_inputs();
        rst = 0;
        tick();
        data_req = 1; inst_req = 1; mem_data_ok = 1; mem_addr_ok = 1;
        settle();
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_ok_pulses", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        tick();
        chk("rst_state", {30'd0, dut.state_q}, {30'd0, ARB_IDLE});
        chk("rst_latch", mem_addr, 0);

        // ---------------- single data read
        do_reset();
        data_req = 1; data_addr = 32'h8000_1000;
        settle();
        chk("rd_t0_stall", {31'd0, stall}, 1);
        chk("rd_t0_mem_req", {31'd0, mem_req}, 0);
        tick();
        chk("rd_t1_mem_req", {31'd0, mem_req}, 1);
        chk("rd_t1_addr", mem_addr, 32'h8000_1000);
        chk("rd_t1_daok", {31'd0, data_addr_ok}, 0);
        tick();
        mem_addr_ok = 1;
        settle();
        chk("rd_t2_daok", {31'd0, data_addr_ok}, 1);
        chk("rd_t2_iaok", {31'd0, inst_addr_ok}, 0);
        chk("rd_t2_stall", {31'd0, stall}, 1);
        tick();
        data_req = 0; mem_addr_ok = 0;
        settle();
        chk("rd_t3_mem_req", {31'd0, mem_req}, 0);
        chk("rd_t3_stall", {31'd0, stall}, 1);
        chk("rd_t3_ddok", {31'd0, data_data_ok}, 0);
        tick();
        mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("rd_t4_ddok", {31'd0, data_data_ok}, 1);
        chk("rd_t4_rdata", data_rdata, 32'hDEAD_BEEF);
        chk("rd_t4_idok", {31'd0, inst_data_ok}, 0);
        chk("rd_t4_stall", {31'd0, stall}, 0);
        tick();
        mem_data_ok = 0;
        settle();
        chk("rd_t5_stall", {31'd0, stall}, 0);
        chk("rd_t5_state", {30'd0, dut.state_q}, {30'd0, ARB_IDLE});

        // ---------------- conflict with 1-cycle memory: D,D,D,D,I repeated
        exp_d      = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        exp_streak = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        do_reset();
        inst_req = 1; data_req = 1; inst_addr = 32'h100; data_addr = 32'h200;
        mem_addr_ok = 1; mem_data_ok = 1;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk($sformatf("cf%0d_idle_mem_req", i), {31'd0, mem_req}, 0);
            tick();
            chk($sformatf("cf%0d_daok", i), {31'd0, data_addr_ok}, {31'd0, exp_d[i]});
            chk($sformatf("cf%0d_iaok", i), {31'd0, inst_addr_ok}, {31'd0, !exp_d[i]});
            chk($sformatf("cf%0d_addr", i), mem_addr, exp_d[i] ? 32'h200 : 32'h100);
            chk($sformatf("cf%0d_streak", i), {29'd0, dut.streak_q}, {29'd0, exp_streak[i]});
            tick();
            chk($sformatf("cf%0d_ddok", i), {31'd0, data_data_ok}, {31'd0, exp_d[i]});
            chk($sformatf("cf%0d_stall", i), {31'd0, stall}, 1);
            tick();
        end

        // ---------------- MAX_DATA_STREAK=0 instance: inst first, then data
        do_reset();
        inst_req = 1; data_req = 1; inst_addr = 32'h300; data_addr = 32'h400;
        mem_addr_ok = 1;
        tick();
        chk("z_first_iaok", {31'd0, z_inst_addr_ok}, 1);
        chk("z_first_daok", {31'd0, z_data_addr_ok}, 0);
        chk("z_first_addr", z_mem_addr, 32'h300);
        tick();
        inst_req = 0; mem_data_ok = 1;
        settle();
        chk("z_first_idok", {31'd0, z_inst_data_ok}, 1);
        chk("z_first_stall", {31'd0, z_stall}, 1);
        tick();
        mem_data_ok = 0;
        tick();
        chk("z_second_daok", {31'd0, z_data_addr_ok}, 1);
        chk("z_second_addr", z_mem_addr, 32'h400);

        // ---------------- write with addr_ok held off 3 cycles
        do_reset();
        data_req = 1; data_wen = 4'b0011; data_addr = 32'h10; data_wdata = 32'h1234_5678;
        tick();
        data_addr = 32'hFFFF_0000; data_wdata = 32'hA5A5_A5A5; data_wen = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("wr_wait%0d_mem_req", i), {31'd0, mem_req}, 1);
            chk($sformatf("wr_wait%0d_wen", i), {28'd0, mem_wen}, 32'h3);
            chk($sformatf("wr_wait%0d_addr", i), mem_addr, 32'h10);
            chk($sformatf("wr_wait%0d_wdata", i), mem_wdata, 32'h1234_5678);
            chk($sformatf("wr_wait%0d_daok", i), {31'd0, data_addr_ok}, 0);
            tick();
        end
        mem_addr_ok = 1;
        settle();
        chk("wr_daok", {31'd0, data_addr_ok}, 1);
        chk("wr_wdata_hold", mem_wdata, 32'h1234_5678);
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        settle();
        chk("wr_ddok", {31'd0, data_data_ok}, 1);
        chk("wr_inst_pulses", {30'd0, inst_addr_ok, inst_data_ok}, 0);
        chk("wr_resp_mem_req", {31'd0, mem_req}, 0);
        tick();
        mem_data_ok = 0;

        // ---------------- reset during RESP, stale response afterwards
        do_reset();
        data_req = 1; data_addr = 32'h44; mem_addr_ok = 1;
        tick();
        tick();
        data_req = 0; mem_addr_ok = 0;
        rst = 0;
        settle();
        chk("mid_rst_stall", {31'd0, stall}, 0);
        chk("mid_rst_mem_req", {31'd0, mem_req}, 0);
        tick();
        rst = 1; mem_data_ok = 1; mem_rdata = 32'hBAD0_BAD0;
        settle();
        chk("stale_state", {30'd0, dut.state_q}, {30'd0, ARB_IDLE});
        chk("stale_ddok", {31'd0, data_data_ok}, 0);
        chk("stale_mem_req", {31'd0, mem_req}, 0);
        chk("stale_stall", {31'd0, stall}, 0);
        tick();
        mem_data_ok = 0;

        // ---------------- back-to-back fetches, data idle
        do_reset();
        inst_req = 1; inst_addr = 32'h1000; mem_addr_ok = 1; mem_data_ok = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk($sformatf("bb%0d_idle_mem_req", i), {31'd0, mem_req}, 0);
            chk($sformatf("bb%0d_idle_stall", i), {31'd0, stall}, 1);
            tick();
            chk($sformatf("bb%0d_req_mem_req", i), {31'd0, mem_req}, 1);
            chk($sformatf("bb%0d_iaok", i), {31'd0, inst_addr_ok}, 1);
            tick();
            chk($sformatf("bb%0d_resp_mem_req", i), {31'd0, mem_req}, 0);
            chk($sformatf("bb%0d_idok", i), {31'd0, inst_data_ok}, 1);
            chk($sformatf("bb%0d_resp_stall", i), {31'd0, stall}, 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory port between the instruction-fetch requester (IF/ID) and the data requester (EX/MEM).
- Carries one outstanding transaction at a time, using an addr_ok/data_ok handshake toward both requesters and the memory.
- Data accesses win conflicts, with a bounded-streak fairness counter so fetch is never starved.
- Raises a stall request to CTRL while any requester is waiting.

Parameters:
- MAX_DATA_STREAK, 4: consecutive data grants allowed while inst is waiting before inst is forced through. 0 = inst always wins conflicts.
- STREAK_W, 3: width of the streak counter. Must hold MAX_DATA_STREAK.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on rising clk)
- inst_req  in  1  fetch request; held until inst_addr_ok
- inst_wen  in  4  byte write enables (0 = read)
- inst_addr  in  32  fetch address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  one-cycle pulse: fetch request accepted by memory
- inst_data_ok  out  1  one-cycle pulse: fetch complete, inst_rdata valid
- inst_rdata  out  32  fetch read data
- data_req, data_wen, data_addr, data_wdata  in  1/4/32/32  same meaning, data side
- data_addr_ok, data_data_ok  out  1/1  same meaning, data side
- data_rdata  out  32  data read data
- mem_req  out  1  request to memory
- mem_wen  out  4  latched byte enables
- mem_addr  out  32  latched address
- mem_wdata  out  32  latched write data
- mem_addr_ok  in  1  memory accepted request this cycle
- mem_data_ok  in  1  memory response this cycle; mem_rdata valid
- mem_rdata  in  32  memory read data
- stallreq_for_mem  out  1  pipeline stall request to CTRL

Behaviour:
- States: IDLE, REQ, RESP. Registers: state, owner (INST/DATA), wen/addr/wdata latches, streak counter.
- Reset (rst==0):
  - state=IDLE, owner=INST, latches=0, streak=0.
  - All outputs 0: mem_req, both addr_ok, both data_ok, stallreq_for_mem.
  - rdata outputs = mem_rdata passthrough (don't-care).
- IDLE:
  - If either req=1, pick a winner, latch its wen/addr/wdata, set owner, go to REQ next cycle.
  - No memory output this cycle. Minimum latency: req at cycle t gives mem_req=1 at t+1.
- Winner selection:
  - Only one requesting: that one.
  - Both requesting: DATA if streak<MAX_DATA_STREAK, else INST.
  - Streak update: granting DATA with inst_req=1 gives streak+1 (saturating). Granting INST, or DATA with inst_req=0, gives streak=0.
- REQ:
  - mem_req=1, with mem_wen/addr/wdata driven from the latches.
  - When mem_addr_ok=1: pulse the owner's addr_ok for the same cycle (combinational), go to RESP.
  - Otherwise hold all outputs stable.
- RESP:
  - mem_req=0.
  - When mem_data_ok=1: owner's data_ok=1 the same cycle, owner's rdata=mem_rdata, go to IDLE.
  - The non-owner's data_ok is always 0.
- Writes (wen!=0) follow the same sequence. data_ok signals write completion; rdata is don't-care.
- mem_data_ok while in IDLE or REQ (stale response after reset) is ignored; no data_ok is generated.
- A requester changing its addr/wdata before addr_ok is illegal. The arbiter always uses the latched copy.
- A request arriving while busy waits. It is evaluated in the IDLE cycle after data_ok, giving one bubble cycle between transactions.
- stallreq_for_mem:
  - IDLE: inst_req|data_req.
  - REQ: 1.
  - RESP: 1, except 0 in the cycle mem_data_ok=1 when the non-owner's req=0.
- Reset mid-transaction: return to IDLE immediately and drop mem_req. The in-flight response is discarded per the stale-response rule above.

Decomposition:
- Shared defines header gets:
  - state encodings ARB_IDLE/ARB_REQ/ARB_RESP (2 bits)
  - owner codes ARB_OWN_INST=0, ARB_OWN_DATA=1
  - bus width macro for the latched request (4+32+32).
- One combinational sub-module, arb_pick:
  - inputs: inst_req, data_req, streak
  - outputs: grant_data, streak_next
- FSM, latches and handshake muxing stay in mem_port_arbiter.

Test Plan:
- Single data read: data_req=1 addr=0x80001000; mem_addr_ok at t+2, mem_data_ok with 0xDEADBEEF at t+4 -> data_addr_ok pulse at t+2, data_data_ok at t+4, data_rdata=0xDEADBEEF, inst_* outputs 0, stall high t..t+3, low at t+4.
- Conflict: both req every cycle, MAX_DATA_STREAK=4, 1-cycle memory -> grant order D,D,D,D,I,D,D,D,D,I; streak returns to 0 after each I.
- MAX_DATA_STREAK=0, both req -> inst granted first, then data.
- Write: data_wen=4'b0011, addr=0x10, wdata=0x12345678; memory stalls addr_ok 3 cycles -> mem_* latched and stable throughout, data_data_ok pulse, no inst pulses.
- Reset asserted (rst=0) in RESP, then mem_data_ok=1 after release -> state IDLE, no data_ok pulse, mem_req=0, stall=0.
- Back-to-back fetches with data idle: inst_req held high -> mem_req pattern 0,1,(resp),0,1 with exactly one IDLE bubble between transactions; stall drops only in data_ok cycles when no other req is pending.
